// File: rtl/ring_stop.sv
// One stop on a unidirectional packet ring: forwards transit traffic, ejects packets
// addressed to this node, and injects local PE packets from a small FIFO into free slots.
module ring_stop #(
    parameter int NODE_ID       = 0,
    parameter int NUM_NODES     = 64,
    parameter int NODE_ID_WIDTH = 6,
    parameter int PAYLOAD_WIDTH = 103,
    parameter int INJ_DEPTH     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NODE_ID_WIDTH+PAYLOAD_WIDTH-1:0] pe_pkt,
    input  logic                                   pe_valid,
    output logic                                   pe_ready,
    input  logic [NODE_ID_WIDTH+PAYLOAD_WIDTH-1:0] ring_in_pkt,
    input  logic                                   ring_in_valid,
    output logic [NODE_ID_WIDTH+PAYLOAD_WIDTH-1:0] ring_out_pkt,
    output logic                                   ring_out_valid,
    output logic [PAYLOAD_WIDTH-1:0]               eject_data,
    output logic                                   eject_valid,
    output logic                                   inj_empty
);

    localparam int PKT_W = NODE_ID_WIDTH + PAYLOAD_WIDTH;
    localparam int PTR_W = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [NODE_ID_WIDTH-1:0] LOCAL_ID = NODE_ID_WIDTH'(NODE_ID);

    logic [PKT_W-1:0]         mem_q [INJ_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]         occ_q, occ_d;
    logic                     ring_out_valid_q, ring_out_valid_d;
    logic                     eject_valid_q, eject_valid_d;
    logic [PKT_W-1:0]         ring_out_pkt_q;
    logic [PAYLOAD_WIDTH-1:0] eject_data_q;

    logic             push, pop, fifo_empty, head_valid;
    logic [PKT_W-1:0] head_pkt;
    logic             ring_eject, ring_fwd, head_local, head_fwd, head_loop;

    assign fifo_empty = (occ_q == '0);
    assign pe_ready   = (occ_q < OCC_W'(INJ_DEPTH));
    assign inj_empty  = fifo_empty;
    assign push       = pe_valid & pe_ready;

    // An empty FIFO is bypassed so a fresh push can leave on the very next edge.
    assign head_valid = ~fifo_empty | push;
    assign head_pkt   = fifo_empty ? pe_pkt : mem_q[rd_ptr_q];

    always_comb begin
        ring_eject = ring_in_valid & (ring_in_pkt[PKT_W-1:PAYLOAD_WIDTH] == LOCAL_ID);
        ring_fwd   = ring_in_valid & ~ring_eject;
        head_local = (head_pkt[PKT_W-1:PAYLOAD_WIDTH] == LOCAL_ID);
        head_fwd   = head_valid & ~ring_fwd & ~head_local;
        head_loop  = head_valid & ~ring_fwd & head_local & ~ring_eject;
        pop        = head_fwd | head_loop;

        ring_out_valid_d = ring_fwd | head_fwd;
        eject_valid_d    = ring_eject | head_loop;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            ring_out_valid_q <= 1'b0;
            eject_valid_q    <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            ring_out_valid_q <= ring_out_valid_d;
            eject_valid_q    <= eject_valid_d;
        end
    end

    // Storage and data registers are not reset; they only load on a grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push) begin
                mem_q[wr_ptr_q] <= pe_pkt;
            end
            if (ring_fwd) begin
                ring_out_pkt_q <= ring_in_pkt;
            end else if (head_fwd) begin
                ring_out_pkt_q <= head_pkt;
            end
            if (ring_eject) begin
                eject_data_q <= ring_in_pkt[PAYLOAD_WIDTH-1:0];
            end else if (head_loop) begin
                eject_data_q <= head_pkt[PAYLOAD_WIDTH-1:0];
            end
        end
    end

    assign ring_out_pkt   = ring_out_pkt_q;
    assign ring_out_valid = ring_out_valid_q;
    assign eject_data     = eject_data_q;
    assign eject_valid    = eject_valid_q;

endmodule

// File: tb/tb_ring_stop.sv
// Bench for ring_stop at NODE_ID=5 against a queue-based model of the slot arbitration rules.
module tb_ring_stop;

    localparam int NID   = 5;
    localparam int IDW   = 6;
    localparam int PLW   = 103;
    localparam int PKW   = IDW + PLW;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [PKW-1:0] pe_pkt = '0;
    logic           pe_valid = 1'b0;
    logic           pe_ready;
    logic [PKW-1:0] ring_in_pkt = '0;
    logic           ring_in_valid = 1'b0;
    logic [PKW-1:0] ring_out_pkt;
    logic           ring_out_valid;
    logic [PLW-1:0] eject_data;
    logic           eject_valid;
    logic           inj_empty;

    // NUM_NODES=40 leaves dst codes 40..63 out of range.
    ring_stop #(
        .NODE_ID(NID), .NUM_NODES(40), .NODE_ID_WIDTH(IDW),
        .PAYLOAD_WIDTH(PLW), .INJ_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .pe_pkt(pe_pkt), .pe_valid(pe_valid), .pe_ready(pe_ready),
        .ring_in_pkt(ring_in_pkt), .ring_in_valid(ring_in_valid),
        .ring_out_pkt(ring_out_pkt), .ring_out_valid(ring_out_valid),
        .eject_data(eject_data), .eject_valid(eject_valid),
        .inj_empty(inj_empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [PKW-1:0] q[$];
    logic           exp_rv, exp_ev;
    logic [PKW-1:0] exp_ro;
    logic [PLW-1:0] exp_ed;
    bit             ro_known = 0, ed_known = 0;

    task automatic chk(input string tag, input logic [PKW-1:0] obs, input logic [PKW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [PKW-1:0] mk(input int dst);
        logic [127:0] r;
        logic [5:0]   d;
        r = {$urandom, $urandom, $urandom, $urandom};
        d = dst[5:0];
        return {d, r[PLW-1:0]};
    endfunction

    // One clock: update the model from the applied inputs, then compare after the edge.
    task automatic cycle();
        logic [PKW-1:0] h;
        logic [PKW-1:0] rp;
        bit slot_busy, eject_busy;
        slot_busy  = 0;
        eject_busy = 0;
        exp_rv = 1'b0;
        exp_ev = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (pe_valid && q.size() < DEPTH) q.push_back(pe_pkt);
            rp = ring_in_pkt;
            if (ring_in_valid) begin
                if (int'(rp[PKW-1:PLW]) == NID) begin
                    exp_ev = 1'b1; exp_ed = rp[PLW-1:0]; eject_busy = 1;
                end else begin
                    exp_rv = 1'b1; exp_ro = rp; slot_busy = 1;
                end
            end
            if (!slot_busy && q.size() > 0) begin
                h = q[0];
                if (int'(h[PKW-1:PLW]) != NID) begin
                    exp_rv = 1'b1; exp_ro = h; void'(q.pop_front());
                end else if (!eject_busy) begin
                    exp_ev = 1'b1; exp_ed = h[PLW-1:0]; void'(q.pop_front());
                end
            end
        end
        @(posedge clk);
        #1;
        chk("ring_out_valid", PKW'(ring_out_valid), PKW'(exp_rv));
        chk("eject_valid", PKW'(eject_valid), PKW'(exp_ev));
        chk("pe_ready", PKW'(pe_ready), PKW'(q.size() < DEPTH));
        chk("inj_empty", PKW'(inj_empty), PKW'(q.size() == 0));
        if (exp_rv) ro_known = 1;
        if (exp_ev) ed_known = 1;
        if (ro_known) chk("ring_out_pkt", ring_out_pkt, exp_ro);
        if (ed_known) chk("eject_data", PKW'(eject_data), PKW'(exp_ed));
    endtask

    task automatic step(input bit rs, input bit pv, input logic [PKW-1:0] pp,
                        input bit rv, input logic [PKW-1:0] rp);
        rst = rs; pe_valid = pv; pe_pkt = pp; ring_in_valid = rv; ring_in_pkt = rp;
        cycle();
    endtask

    initial begin
        logic [PKW-1:0] p;
        int d;

        step(1, 0, '0, 0, '0);
        step(1, 1, mk(9), 1, mk(9));
        chk("reset_pe_ready", PKW'(pe_ready), PKW'(1));

        // Ring packet for this node is ejected one cycle later.
        p = {6'd5, 103'h1A};
        step(0, 0, '0, 1, p);
        chk("eject_1A", PKW'(eject_data), PKW'(103'h1A));
        chk("eject_1A_no_fwd", PKW'(ring_out_valid), PKW'(0));

        // Continuous transit traffic starves injection; FIFO fills after 4 pushes.
        for (int i = 0; i < 10; i++) step(0, i < 5, mk(12), 1, mk(9));
        chk("full_pe_ready", PKW'(pe_ready), PKW'(0));
        for (int i = 0; i < 4; i++) begin
            step(0, 0, '0, 0, '0);
            chk("drain_valid", PKW'(ring_out_valid), PKW'(1));
        end
        chk("drained_empty", PKW'(inj_empty), PKW'(1));

        // Full FIFO: ring ejection and head injection in the same cycle.
        for (int i = 0; i < 4; i++) step(0, 1, mk(12), 1, mk(9));
        step(0, 0, '0, 1, mk(5));
        chk("dual_eject", PKW'(eject_valid), PKW'(1));
        chk("dual_inject", PKW'(ring_out_valid), PKW'(1));
        chk("dual_ready", PKW'(pe_ready), PKW'(1));
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0);

        // Loopback head loses the eject port to ring traffic, then goes next cycle.
        step(0, 1, mk(5), 1, mk(9));
        step(0, 0, '0, 1, mk(5));
        step(0, 0, '0, 0, '0);
        chk("loopback_late", PKW'(eject_valid), PKW'(1));
        step(0, 0, '0, 0, '0);

        // Steady push/pop at occupancy 2 wraps the pointers.
        for (int i = 0; i < 2; i++) step(0, 1, mk(12), 1, mk(9));
        for (int i = 0; i < 8; i++) step(0, 1, mk(12), 0, '0);
        for (int i = 0; i < 2; i++) step(0, 0, '0, 0, '0);

        // Out-of-range destinations are forwarded; reset mid-traffic flushes everything.
        for (int i = 0; i < 3; i++) step(0, 1, mk(45), 1, mk(50));
        step(1, 1, mk(12), 1, mk(50));
        chk("rst_empty", PKW'(inj_empty), PKW'(1));
        chk("rst_rv", PKW'(ring_out_valid), PKW'(0));
        step(0, 1, mk(5), 0, '0);
        chk("post_rst_push", PKW'(eject_valid), PKW'(1));

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(4))
                0: d = 5;
                1: d = 9;
                2: d = 45;
                3: d = 12;
                default: d = int'($urandom_range(63));
            endcase
            p = mk(d);
            step($urandom_range(63) == 0, $urandom_range(1) == 1, p,
                 $urandom_range(2) != 0, mk($urandom_range(1) == 1 ? 5 : int'($urandom_range(63))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
